// File: rtl/weight_kernel_loader.sv
// Double-banked kernel assembler: collects dim weight elements per kernel from the
// weight-buffer stream and presents each full kernel as one flat word with valid/ack.
`timescale 1ns/1ps

module weight_kernel_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_ELEMS  = 25
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [4:0]                      cfg_dim,
    input  logic [7:0]                      cfg_kernels,
    input  logic                            in_vld,
    input  logic [DATA_WIDTH-1:0]           in_data,
    output logic                            in_rdy,
    output logic                            kernel_vld,
    output logic [MAX_ELEMS*DATA_WIDTH-1:0] kernel_data,
    input  logic                            kernel_ack,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [4:0] MAX_DIM = 5'(MAX_ELEMS);

    state_t                state;
    logic [DATA_WIDTH-1:0] bank [2][MAX_ELEMS];
    logic [4:0]            dim;
    logic [7:0]            nk;
    logic [7:0]            kcnt;
    logic [4:0]            wr_idx;
    logic                  wr_sel;
    logic                  rd_sel;
    logic [1:0]            full;
    logic [1:0]            full_next;

    logic accept;
    logic wr_last;
    logic rd_fire;

    function automatic logic [4:0] clamp_dim(input logic [4:0] d);
        if (d == 5'd0)
            return 5'd1;
        else if (d > MAX_DIM)
            return MAX_DIM;
        else
            return d;
    endfunction

    assign in_rdy     = (state == LOAD) && !full[wr_sel];
    assign kernel_vld = full[rd_sel];
    assign busy       = (state != IDLE);
    assign accept     = in_vld && in_rdy;
    assign wr_last    = (wr_idx == dim - 5'd1);
    assign rd_fire    = kernel_ack && kernel_vld;

    // A fill can only complete into an empty bank and an ack only frees a full one,
    // so the two updates always touch different bits.
    always_comb begin
        // NOTE: every signal written here gets a default first, otherwise a latch is inferred.
        full_next = full;
        if (accept && wr_last)
            full_next[wr_sel] = 1'b1;
        if (rd_fire)
            full_next[rd_sel] = 1'b0;
    end

    // Slots past the active dimension are masked so stale data never reaches the PEs.
    always_comb begin
        kernel_data = '0;
        for (int i = 0; i < MAX_ELEMS; i++) begin
            if (i < int'(dim))
                kernel_data[i*DATA_WIDTH +: DATA_WIDTH] = bank[rd_sel][i];
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            dim          <= 5'd1;
            nk           <= '0;
            kcnt         <= '0;
            wr_idx       <= '0;
            wr_sel       <= 1'b0;
            rd_sel       <= 1'b0;
            full         <= '0;
            done         <= 1'b0;
            overflow_err <= 1'b0;
            // NOTE: the banks are cleared on reset because the reset state must present an all-zero kernel.
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < MAX_ELEMS; i++)
                    bank[b][i] <= '0;
        end else begin
            done <= 1'b0;
            full <= full_next;

            if (in_vld && !in_rdy && state != IDLE)
                overflow_err <= 1'b1;

            if (accept) begin
                bank[wr_sel][wr_idx] <= in_data;
                if (wr_last) begin
                    wr_idx <= '0;
                    wr_sel <= ~wr_sel;
                    kcnt   <= kcnt + 8'd1;
                end else begin
                    wr_idx <= wr_idx + 5'd1;
                end
            end

            if (rd_fire)
                rd_sel <= ~rd_sel;

            case (state)
                IDLE: begin
                    if (start) begin
                        dim          <= clamp_dim(cfg_dim);
                        nk           <= cfg_kernels;
                        kcnt         <= '0;
                        overflow_err <= 1'b0;
                        state        <= (cfg_kernels == 8'd0) ? DRAIN : LOAD;
                    end
                end
                LOAD: begin
                    if (accept && wr_last && (kcnt + 8'd1 == nk))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (full == 2'b00) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_kernel_loader.sv
// Directed bench for weight_kernel_loader: hand-computed kernels, handshake timing,
// clamping, reset mid-job and ignored start.
`timescale 1ns/1ps

module tb_weight_kernel_loader;

    localparam int DW = 16;
    localparam int ME = 25;
    localparam int KW = ME * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    cfg_dim = '0;
    logic [7:0]    cfg_kernels = '0;
    logic          in_vld = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_rdy;
    logic          kernel_vld;
    logic [KW-1:0] kernel_data;
    logic          kernel_ack = 1'b0;
    logic          busy;
    logic          done;
    logic          overflow_err;

    int n_checks = 0;
    int n_errors = 0;

    weight_kernel_loader #(.DATA_WIDTH(DW), .MAX_ELEMS(ME)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_dim      (cfg_dim),
        .cfg_kernels  (cfg_kernels),
        .in_vld       (in_vld),
        .in_data      (in_data),
        .in_rdy       (in_rdy),
        .kernel_vld   (kernel_vld),
        .kernel_data  (kernel_data),
        .kernel_ack   (kernel_ack),
        .busy         (busy),
        .done         (done),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [KW-1:0] got, input logic [KW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Kernel with slot i = base+i for i < n, zero elsewhere.
    function automatic logic [KW-1:0] make_kernel(input int base, input int n);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < n; i++)
            k[i*DW +: DW] = 16'(base + i);
        return k;
    endfunction

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [4:0] d, input logic [7:0] n);
        start       = 1'b1;
        cfg_dim     = d;
        cfg_kernels = n;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input int v);
        in_vld  = 1'b1;
        in_data = 16'(v);
        step();
        in_vld  = 1'b0;
    endtask

    task automatic ack();
        kernel_ack = 1'b1;
        step();
        kernel_ack = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_rdy"},     KW'(in_rdy),       '0);
        check({tag, "_kvld"},       KW'(kernel_vld),   '0);
        check({tag, "_kdata"},      kernel_data,       '0);
        check({tag, "_busy"},       KW'(busy),         '0);
        check({tag, "_done"},       KW'(done),         '0);
        check({tag, "_overflow"},   KW'(overflow_err), '0);
    endtask

    initial begin
        // Reset state
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        // T1: dim=9, nk=1, elements 1..9
        start_job(5'd9, 8'd1);
        check("t1_busy", KW'(busy), KW'(1));
        check("t1_in_rdy", KW'(in_rdy), KW'(1));
        for (int k = 1; k <= 8; k++)
            feed(k);
        check("t1_vld_before_last", KW'(kernel_vld), '0);
        feed(9);
        check("t1_vld", KW'(kernel_vld), KW'(1));
        check("t1_data", kernel_data, make_kernel(1, 9));
        check("t1_in_rdy_drain", KW'(in_rdy), '0);
        step();
        check("t1_data_held", kernel_data, make_kernel(1, 9));
        ack();
        check("t1_vld_after_ack", KW'(kernel_vld), '0);
        check("t1_done_early", KW'(done), '0);
        step();
        check("t1_done", KW'(done), KW'(1));
        check("t1_busy_drop", KW'(busy), '0);
        step();
        check("t1_done_pulse", KW'(done), '0);

        // T2: dim=4, nk=3, no ack until 12 elements offered
        start_job(5'd4, 8'd3);
        for (int k = 1; k <= 4; k++)
            feed(10 + k);
        check("t2_vld_bank0", KW'(kernel_vld), KW'(1));
        check("t2_rdy_bank1_free", KW'(in_rdy), KW'(1));
        for (int k = 5; k <= 8; k++)
            feed(10 + k);
        check("t2_rdy_both_full", KW'(in_rdy), '0);
        check("t2_no_overflow_yet", KW'(overflow_err), '0);
        for (int k = 9; k <= 12; k++)
            feed(10 + k);
        check("t2_overflow", KW'(overflow_err), KW'(1));
        check("t2_data_bank0", kernel_data, make_kernel(11, 4));
        ack();
        check("t2_rdy_after_ack", KW'(in_rdy), KW'(1));
        check("t2_data_bank1", kernel_data, make_kernel(15, 4));
        for (int k = 21; k <= 24; k++)
            feed(k);
        check("t2_drain_rdy", KW'(in_rdy), '0);
        check("t2_overflow_sticky", KW'(overflow_err), KW'(1));
        ack();
        check("t2_data_bank0_third", kernel_data, make_kernel(21, 4));
        ack();
        check("t2_vld_empty", KW'(kernel_vld), '0);
        step();
        check("t2_done", KW'(done), KW'(1));
        step();

        // T3: ack bank0 in the cycle bank1 completes
        start_job(5'd4, 8'd2);
        check("t3_overflow_cleared", KW'(overflow_err), '0);
        for (int k = 1; k <= 4; k++)
            feed(k);
        for (int k = 5; k <= 7; k++)
            feed(k);
        check("t3_bank0_held", kernel_data, make_kernel(1, 4));
        in_vld     = 1'b1;
        in_data    = 16'd8;
        kernel_ack = 1'b1;
        step();
        in_vld     = 1'b0;
        kernel_ack = 1'b0;
        check("t3_vld_no_gap", KW'(kernel_vld), KW'(1));
        check("t3_data_bank1", kernel_data, make_kernel(5, 4));
        check("t3_done_early", KW'(done), '0);
        ack();
        step();
        check("t3_done", KW'(done), KW'(1));
        step();

        // T4a: cfg_dim=0 clamps to 1
        start_job(5'd0, 8'd3);
        feed(16'h77);
        check("t4a_k0", kernel_data, make_kernel(16'h77, 1));
        in_vld     = 1'b1;
        in_data    = 16'h88;
        kernel_ack = 1'b1;
        step();
        check("t4a_k1", kernel_data, make_kernel(16'h88, 1));
        in_data = 16'h99;
        step();
        in_vld     = 1'b0;
        kernel_ack = 1'b0;
        check("t4a_k2", kernel_data, make_kernel(16'h99, 1));
        check("t4a_drain", KW'(in_rdy), '0);
        ack();
        step();
        check("t4a_done", KW'(done), KW'(1));
        step();

        // T4b: cfg_dim=31 clamps to 25
        start_job(5'd31, 8'd1);
        for (int k = 0; k < 24; k++)
            feed(100 + k);
        check("t4b_vld_before_25", KW'(kernel_vld), '0);
        feed(124);
        check("t4b_vld", KW'(kernel_vld), KW'(1));
        check("t4b_data", kernel_data, make_kernel(100, 25));
        ack();
        step();
        check("t4b_done", KW'(done), KW'(1));
        step();

        // T4c: nk=0 goes straight to DRAIN
        start_job(5'd3, 8'd0);
        check("t4c_busy", KW'(busy), KW'(1));
        check("t4c_in_rdy", KW'(in_rdy), '0);
        check("t4c_done_early", KW'(done), '0);
        step();
        check("t4c_done", KW'(done), KW'(1));
        step();

        // T5: reset after 5 of 9 elements
        start_job(5'd9, 8'd1);
        for (int k = 1; k <= 5; k++)
            feed(k);
        rst = 1'b1;
        step();
        check_all_zero("t5_rst");
        rst = 1'b0;
        start_job(5'd3, 8'd1);
        for (int k = 51; k <= 53; k++)
            feed(k);
        check("t5_vld", KW'(kernel_vld), KW'(1));
        check("t5_data", kernel_data, make_kernel(51, 3));
        ack();
        step();
        check("t5_done", KW'(done), KW'(1));
        step();

        // T6: start during LOAD is ignored
        start_job(5'd4, 8'd2);
        feed(1);
        feed(2);
        start       = 1'b1;
        cfg_dim     = 5'd2;
        cfg_kernels = 8'd1;
        in_vld      = 1'b1;
        in_data     = 16'd3;
        step();
        start  = 1'b0;
        in_vld = 1'b0;
        check("t6_no_early_kernel", KW'(kernel_vld), '0);
        feed(4);
        check("t6_data", kernel_data, make_kernel(1, 4));
        check("t6_still_loading", KW'(in_rdy), KW'(1));
        for (int k = 5; k <= 8; k++)
            feed(k);
        check("t6_drain", KW'(in_rdy), '0);
        ack();
        check("t6_data_bank1", kernel_data, make_kernel(5, 4));
        ack();
        step();
        check("t6_done", KW'(done), KW'(1));
        check("t6_overflow", KW'(overflow_err), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
